// File: rtl/descriptor_prefetch_buffer_if.sv
// Handshake bundle between the prefetch buffer, the descriptor allocator and the enqueue path.
// Latency: none, wires only.
// Backpressure: carries alloc valid/ack, desc valid/pop and free valid/ack pairs.
interface descriptor_prefetch_buffer_if #(
    parameter int DESCRIPTOR_MEM_ADDR_WIDTH = 10,
    parameter int DEPTH                     = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    // allocator offer side
    logic [DESCRIPTOR_MEM_ADDR_WIDTH-1:0] alloc_addr_i;
    logic                                 alloc_valid_i;
    logic                                 alloc_ack_o;
    // enqueue path side
    logic [DESCRIPTOR_MEM_ADDR_WIDTH-1:0] desc_addr_o;
    logic                                 desc_valid_o;
    logic                                 desc_pop_i;
    // flush / return side
    logic                                 flush_i;
    logic [DESCRIPTOR_MEM_ADDR_WIDTH-1:0] free_addr_o;
    logic                                 free_valid_o;
    logic                                 free_ack_i;
    logic                                 flush_done_o;
    logic [LW-1:0]                        level_o;

    // environment side: allocator plus enqueue logic
    modport master (
        output alloc_addr_i, alloc_valid_i, desc_pop_i, flush_i, free_ack_i,
        input  alloc_ack_o, desc_addr_o, desc_valid_o, free_addr_o, free_valid_o,
        input  flush_done_o, level_o
    );

    // prefetch buffer side
    modport slave (
        input  alloc_addr_i, alloc_valid_i, desc_pop_i, flush_i, free_ack_i,
        output alloc_ack_o, desc_addr_o, desc_valid_o, free_addr_o, free_valid_o,
        output flush_done_o, level_o
    );
endinterface

// File: rtl/descriptor_prefetch_buffer.sv
// Show-ahead FIFO of free descriptor addresses prefetched from the allocator; returns leftovers on flush.
// Latency: accept->head visible 1 cycle, pop->next head 1 cycle, flush->first return 1 cycle.
// Backpressure: accepts at most every other cycle and only when not full; returns held until free_ack_i.
module descriptor_prefetch_buffer #(
    parameter int DESCRIPTOR_MEM_ADDR_WIDTH = 10,
    parameter int DEPTH                     = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    descriptor_prefetch_buffer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t state, state_nxt;

    logic [DESCRIPTOR_MEM_ADDR_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    // blocks a second accept of the allocator's registered valid, which falls one cycle after ack
    logic          holdoff;

    logic push, pop, empty;
    logic ack, desc_vld, free_vld, done;

    assign empty = (count == '0);

    // FSM next state and handshake decodes; outputs depend only on registers and alloc_valid_i
    always_comb begin
        state_nxt = state;
        ack       = 1'b0;
        desc_vld  = 1'b0;
        free_vld  = 1'b0;
        done      = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        case (state)
            FILL: begin
                ack      = bus.alloc_valid_i & (count < FULL) & ~holdoff;
                push     = ack;
                desc_vld = ~empty;
                pop      = desc_vld & bus.desc_pop_i;
                if (bus.flush_i) state_nxt = DRAIN;
            end
            DRAIN: begin
                free_vld = ~empty;
                pop      = free_vld & bus.free_ack_i;
                if (empty) begin
                    done      = 1'b1;
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= FILL;
        else          state <= state_nxt;
    end

    // pointers, occupancy and accept holdoff
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            holdoff <= 1'b0;
        end else begin
            holdoff <= push;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // address storage; contents are don't-care until written so it has no reset
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= bus.alloc_addr_i;
    end

    // ack is also masked by reset so nothing is granted while the block is held in reset
    assign bus.alloc_ack_o  = ack & rst_n_i;
    assign bus.desc_valid_o = desc_vld;
    assign bus.desc_addr_o  = desc_vld ? mem[rd_ptr] : '0;
    assign bus.free_valid_o = free_vld;
    assign bus.free_addr_o  = free_vld ? mem[rd_ptr] : '0;
    assign bus.flush_done_o = done;
    assign bus.level_o      = count;
endmodule

// File: tb/tb_descriptor_prefetch_buffer.sv
// Directed bench for descriptor_prefetch_buffer with a queue scoreboard of buffered addresses.
// Latency: checks combinational outputs 1ns after each input change, before the next rising edge.
// Backpressure: exercises holdoff, full, pop/accept overlap, acked drain and reset during drain.
module tb_descriptor_prefetch_buffer;
    logic clk;
    logic rst_n;
    int   vectors = 0;
    int   fails   = 0;

    descriptor_prefetch_buffer_if #(.DESCRIPTOR_MEM_ADDR_WIDTH(10), .DEPTH(8)) bus ();

    descriptor_prefetch_buffer #(.DESCRIPTOR_MEM_ADDR_WIDTH(10), .DEPTH(8)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: addresses the buffer must hold, in order
    logic [9:0] sb [$];
    bit         m_drain;
    bit         m_hold;
    bit         last_ack;
    logic [9:0] na;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: drive inputs at falling edge, check outputs, update scoreboard, wait next falling edge
    task automatic step(input logic v, input logic [9:0] a, input logic p, input logic f, input logic fa);
        int         sz;
        logic       e_ack, e_dv, e_fv, e_done;
        logic [9:0] e_da, e_fa;
        bus.alloc_valid_i = v;
        bus.alloc_addr_i  = a;
        bus.desc_pop_i    = p;
        bus.flush_i       = f;
        bus.free_ack_i    = fa;
        #1;
        sz     = sb.size();
        e_ack  = !m_drain && v && (sz < 8) && !m_hold;
        e_dv   = !m_drain && (sz != 0);
        e_da   = e_dv ? sb[0] : 10'd0;
        e_fv   = m_drain && (sz != 0);
        e_fa   = e_fv ? sb[0] : 10'd0;
        e_done = m_drain && (sz == 0);
        chk("alloc_ack",  32'(bus.alloc_ack_o),  32'(e_ack));
        chk("desc_valid", 32'(bus.desc_valid_o), 32'(e_dv));
        chk("desc_addr",  32'(bus.desc_addr_o),  32'(e_da));
        chk("free_valid", 32'(bus.free_valid_o), 32'(e_fv));
        chk("free_addr",  32'(bus.free_addr_o),  32'(e_fa));
        chk("flush_done", 32'(bus.flush_done_o), 32'(e_done));
        chk("level",      32'(bus.level_o),      32'(sz));
        if (e_dv && p)  void'(sb.pop_front());
        if (e_fv && fa) void'(sb.pop_front());
        if (e_ack)      sb.push_back(a);
        m_hold = e_ack;
        if (!m_drain && f)           m_drain = 1'b1;
        else if (m_drain && sz == 0) m_drain = 1'b0;
        last_ack = e_ack;
        @(negedge clk);
    endtask

    task automatic fill_to(input int n);
        for (int g = 0; g < 40 && sb.size() < n; g++) begin
            step(1'b1, na, 1'b0, 1'b0, 1'b0);
            if (last_ack) na = na + 10'd1;
        end
        step(1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_to(input int n);
        for (int g = 0; g < 20 && sb.size() > n; g++) step(1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".alloc_ack"},  32'(bus.alloc_ack_o),  32'd0);
        chk({tag, ".desc_valid"}, 32'(bus.desc_valid_o), 32'd0);
        chk({tag, ".desc_addr"},  32'(bus.desc_addr_o),  32'd0);
        chk({tag, ".free_valid"}, 32'(bus.free_valid_o), 32'd0);
        chk({tag, ".free_addr"},  32'(bus.free_addr_o),  32'd0);
        chk({tag, ".flush_done"}, 32'(bus.flush_done_o), 32'd0);
        chk({tag, ".level"},      32'(bus.level_o),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        m_drain = 1'b0;
        m_hold  = 1'b0;
        last_ack = 1'b0;
        rst_n = 1'b0;
        bus.alloc_valid_i = 1'b1;
        bus.alloc_addr_i  = 10'd5;
        bus.desc_pop_i    = 1'b0;
        bus.flush_i       = 1'b0;
        bus.free_ack_i    = 1'b0;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // valid held high: ack only every other cycle, saturates at 8
        na = 10'd5;
        for (int i = 0; i < 18; i++) begin
            step(1'b1, na, 1'b0, 1'b0, 1'b0);
            if (last_ack) na = na + 10'd1;
        end
        chk("full_level", 32'(bus.level_o), 32'd8);
        chk("full_head",  32'(bus.desc_addr_o), 32'd5);

        // three back-to-back pops, then a refill lands at the wrapped write pointer
        step(1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
        chk("after_pops_head", 32'(bus.desc_addr_o), 32'd8);
        step(1'b1, na, 1'b0, 1'b0, 1'b0);
        na = na + 10'd1;
        step(1'b0, 10'd0, 1'b0, 1'b0, 1'b0);

        // pop plus accept in one cycle at level 4
        pop_to(4);
        step(1'b1, na, 1'b1, 1'b0, 1'b0);
        na = na + 10'd1;
        chk("overlap_level", 32'(bus.level_o), 32'd4);
        step(1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
        pop_to(0);
        step(1'b0, 10'd0, 1'b1, 1'b0, 1'b0);

        // level 3 flush with free_ack every other cycle; allocator keeps offering during drain
        na = 10'd10;
        fill_to(3);
        step(1'b0, 10'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 10'd20, 1'b0, 1'b1, (i % 2) == 1);
        end
        step(1'b0, 10'd0, 1'b0, 1'b0, 1'b0);

        // flush with empty FIFO
        pop_to(0);
        step(1'b0, 10'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 10'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 10'd0, 1'b0, 1'b0, 1'b0);

        // reset asserted mid-drain at level 2
        na = 10'd40;
        fill_to(2);
        step(1'b0, 10'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_free_valid", 32'(bus.free_valid_o), 32'd1);
        bus.alloc_valid_i = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        sb.delete();
        m_drain = 1'b0;
        m_hold  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 10'd50, 1'b0, 1'b0, 1'b0);
        step(1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 10'd0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/descriptor_prefetch_buffer.md
# descriptor_prefetch_buffer

Client-side consumer of the descriptor allocator's free-address handshake. It pre-fetches free descriptor addresses into a small show-ahead FIFO, so the enqueue path can take a descriptor in zero cycles instead of waiting on the allocator's free-list scan. On flush it returns every buffered, unused address to the allocator through one of its free ports. It sits between the descriptor allocator and the queue-memory enqueue logic.

## Interface
- DESCRIPTOR_MEM_ADDR_WIDTH, 10, width of a descriptor address.
- DEPTH, 8, FIFO entries; power of two, ≥2.
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- alloc_addr_i  in  DESCRIPTOR_MEM_ADDR_WIDTH  free address offered by allocator.
- alloc_valid_i  in  1  allocator offer valid.
- alloc_ack_o  out  1  accept of the current offer.
- desc_addr_o  out  DESCRIPTOR_MEM_ADDR_WIDTH  head address to enqueue path; 0 when desc_valid_o=0.
- desc_valid_o  out  1  head valid.
- desc_pop_i  in  1  enqueue path consumes head.
- flush_i  in  1  single-cycle request to return all buffered addresses.
- free_addr_o  out  DESCRIPTOR_MEM_ADDR_WIDTH  address being returned; 0 when free_valid_o=0.
- free_valid_o  out  1  return request valid.
- free_ack_i  in  1  allocator accepted the return.
- flush_done_o  out  1  one-cycle pulse when drain completes.
- level_o  out  $clog2(DEPTH)+1  buffered entry count.

## Operation
- Storage: DEPTH×addr array, rd_ptr/wr_ptr ($clog2(DEPTH) bits, natural wrap), count (0..DEPTH). Array is not reset.
- FSM states: FILL (reset state), DRAIN.
- FILL:
  - alloc_ack_o = alloc_valid_i & (count<DEPTH) & ~holdoff.
  - Transfer on alloc_valid_i & alloc_ack_o: write alloc_addr_i at wr_ptr and increment wr_ptr.
  - holdoff register is set for exactly one cycle after every transfer. This guards against re-accepting the allocator's registered valid, which drops one cycle after ack.
  - desc_valid_o = count!=0; desc_addr_o = mem[rd_ptr].
  - desc_pop_i with desc_valid_o=1 increments rd_ptr.
  - desc_pop_i while empty is ignored.
  - Push and pop in the same cycle leave count unchanged.
  - flush_i=1 → DRAIN next cycle. A pop in the same cycle still executes first. An accept in the same cycle is still stored and is drained.
- DRAIN:
  - alloc_ack_o=0 and desc_valid_o=0; desc_pop_i is ignored.
  - free_valid_o = count!=0; free_addr_o = mem[rd_ptr].
  - free_valid_o & free_ack_i pops one entry. free_valid_o is held with a stable address until acked.
  - When count==0: flush_done_o pulses, → FILL next cycle. Flush with empty FIFO gives DRAIN for 1 cycle, then done.
  - flush_i in DRAIN is ignored.
- Arithmetic: count±1 saturates only by construction. Overflow (push when full) and underflow are impossible by gating.
- Reset (any time, asynchronous): pointers, count, holdoff and state clear; buffered addresses are discarded. The allocator must be reset concurrently, otherwise those descriptors leak.

## Timing
- Reset values: alloc_ack_o 0, desc_valid_o 0, desc_addr_o 0, free_valid_o 0, free_addr_o 0, flush_done_o 0, level_o 0.
- alloc_ack_o, desc_*, free_* are combinational from registers plus alloc_valid_i. There is no combinational path from desc_pop_i or free_ack_i to any output.
- Accept→desc_valid_o: 1 cycle (address visible the cycle after transfer).
- Pop→next head visible: 1 cycle.
- Maximum fill rate: 1 accept per 2 cycles.
- Drain rate: 1 return per cycle while free_ack_i=1.
- flush_i→first free_valid_o: 1 cycle.
- Last free_ack_i→flush_done_o: 1 cycle, same cycle as count becomes 0 in registers.
- flush_done_o→alloc_ack_o possible: next cycle.

## Test plan
- Reset, then allocator offers 5,6,7,… with valid held high → ack on alternate cycles only; after 16 cycles level_o=8 and alloc_ack_o stays 0; desc_addr_o=5.
- FIFO full (8 entries); pop 3 times back-to-back → desc_addr_o sequence 5,6,7,8; level_o 8→5. Next allocator offer is accepted and stored at wrapped wr_ptr.
- Pop and accept in the same cycle at level 4 → level_o stays 4; FIFO order is preserved.
- Level 3 (addrs 10,11,12), flush_i pulse; free_ack_i high every other cycle → free_addr_o 10,11,12, each held until ack. flush_done_o pulses 1 cycle after the third ack. No alloc_ack_o during the drain; refill resumes after.
- flush_i with empty FIFO → one DRAIN cycle, flush_done_o pulse, back to FILL; free_valid_o never asserted.
- Assert rst_n_i low mid-drain (level 2) → all outputs 0 immediately (asynchronously). After release, state is FILL, level_o=0, and alloc_ack_o follows alloc_valid_i.
